// File: rtl/inst_seq_ctrl.sv
// Fetch/execute sequencer: runs PC against imem or single-steps the bypass word.
// One EXEC cycle per instruction; fetch waits on imem_valid with timeout -> sticky fault.
module inst_seq_ctrl #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            prog_mode,
  input  logic [31:0]     bypass_in,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [31:0]     imem_data,
  input  logic            imem_valid,
  output logic [31:0]     inst_q,
  output logic            d_prog,
  output logic            reg_we,
  output logic [1:0]      reg_rd,
  output logic [1:0]      reg_rs,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            fault,
  output logic [15:0]     retired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd7;

  typedef enum logic [1:0] {IDLE, FETCH, LOADB, EXEC} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       inst_d;
  logic              d_prog_q, d_prog_d;
  logic              reg_we_q, reg_we_d;
  logic              fault_q, fault_d;
  logic [15:0]       retired_q, retired_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      d_prog_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      d_prog_q  <= d_prog_d;
      reg_we_q  <= reg_we_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    d_prog_d  = d_prog_q;
    reg_we_d  = 1'b0;
    fault_d   = fault_q;
    retired_d = retired_q;
    to_cnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          fault_d  = 1'b0;
          d_prog_d = prog_mode;
          state_d  = prog_mode ? LOADB : FETCH;
        end
      end
      FETCH: begin
        // stop beats a same-cycle imem_valid; the word is dropped
        if (stop) begin
          state_d = IDLE;
        end else if (imem_valid) begin
          inst_d   = imem_data;
          reg_we_d = (imem_data[26:24] == OP_ADD);
          state_d  = EXEC;
        end else if (to_cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      LOADB: begin
        inst_d   = bypass_in;
        reg_we_d = (bypass_in[26:24] == OP_ADD);
        state_d  = EXEC;
      end
      EXEC: begin
        retired_d = retired_q + 16'd1;
        pc_d      = (inst_q[26:24] == OP_JUMP) ? inst_q[PC_W-1:0] : pc_q + PC_W'(1);
        state_d   = (d_prog_q || stop) ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign imem_rd   = (state_q == FETCH);
  assign pc        = pc_q;
  assign d_prog    = d_prog_q;
  assign reg_we    = reg_we_q;
  assign reg_rd    = inst_q[17:16];
  assign reg_rs    = inst_q[21:20];
  assign busy      = (state_q != IDLE);
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule
